// File: rtl/ft245_tx_engine.sv
// FT245 transmit engine: a byte FIFO feeding a TXE#/WR# write sequencer on the shared parallel bus.
// State   | meaning
// IDLE    | bus released, waiting for data, TXE# low and no receive activity
// SETUP   | data driven ahead of WR#; a late TXE# high aborts without strobing
// STROBE  | WR# low
// HOLD    | WR# high again, data still driven
// RECOVER | bus released before the next transaction
module ft245_tx_engine #(
  parameter int DEPTH_LOG2  = 4,
  parameter int SETUP_CYC   = 1,
  parameter int STROBE_CYC  = 2,
  parameter int HOLD_CYC    = 1,
  parameter int RECOVER_CYC = 2
) (
  input  logic                hwclk,
  input  logic                rst_n,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                txe_245,
  input  logic                rx_active,
  output logic                wr_245,
  output logic [7:0]          data_245,
  output logic                oe_245,
  output logic                tx_bus_owned,
  output logic [DEPTH_LOG2:0] fifo_count
);

  if (DEPTH_LOG2 < 1 || SETUP_CYC < 1 || STROBE_CYC < 1 || HOLD_CYC < 1 || RECOVER_CYC < 1) begin : g_bad_param
    $error("ft245_tx_engine: all parameters must be >= 1");
  end

  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int MAX_SH  = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int MAX_SR  = (STROBE_CYC > RECOVER_CYC) ? STROBE_CYC : RECOVER_CYC;
  localparam int MAX_CYC = (MAX_SH > MAX_SR) ? MAX_SH : MAX_SR;
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TW-1:0]         LD_SETUP   = TW'(SETUP_CYC - 1);
  localparam logic [TW-1:0]         LD_STROBE  = TW'(STROBE_CYC - 1);
  localparam logic [TW-1:0]         LD_HOLD    = TW'(HOLD_CYC - 1);
  localparam logic [TW-1:0]         LD_RECOVER = TW'(RECOVER_CYC - 1);
  localparam logic [TW-1:0]         TMR_ONE    = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE    = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL   = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_RECOVER} state_t;

  logic                  txe_m, txe_s;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic                  push, pop;
  state_t                state, state_nxt;
  logic [TW-1:0]         tmr, tmr_nxt;
  logic                  tmr_done;
  logic                  wr_nxt, oe_nxt;
  logic [7:0]            data_nxt;

  // TXE# is driven by the FTDI asynchronously to hwclk; reset to "not ready".
  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      txe_m <= 1'b1;
      txe_s <= 1'b1;
    end else begin
      txe_m <= txe_245;
      txe_s <= txe_m;
    end
  end

  assign in_ready = rst_n && (fifo_count != CNT_FULL);
  assign push     = in_valid && in_ready;

  always_ff @(posedge hwclk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_ONE;
        2'b01:   fifo_count <= fifo_count - CNT_ONE;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      tmr          <= '0;
      wr_245       <= 1'b1;
      oe_245       <= 1'b0;
      data_245     <= '0;
      tx_bus_owned <= 1'b0;
    end else begin
      state        <= state_nxt;
      tmr          <= tmr_nxt;
      wr_245       <= wr_nxt;
      oe_245       <= oe_nxt;
      data_245     <= data_nxt;
      tx_bus_owned <= (state_nxt != S_IDLE);
    end
  end

  assign tmr_done = (tmr == '0);

  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr_done ? tmr : tmr - TMR_ONE;
    case (state)
      S_IDLE:
        if (fifo_count != '0 && !txe_s && !rx_active) begin
          state_nxt = S_SETUP;
          tmr_nxt   = LD_SETUP;
        end
      S_SETUP:
        if (txe_s) begin
          state_nxt = S_RECOVER;
          tmr_nxt   = LD_RECOVER;
        end else if (tmr_done) begin
          state_nxt = S_STROBE;
          tmr_nxt   = LD_STROBE;
        end
      S_STROBE:
        if (tmr_done) begin
          state_nxt = S_HOLD;
          tmr_nxt   = LD_HOLD;
        end
      S_HOLD:
        if (tmr_done) begin
          state_nxt = S_RECOVER;
          tmr_nxt   = LD_RECOVER;
        end
      S_RECOVER:
        if (tmr_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so they change on the same edge as the state.
  always_comb begin
    wr_nxt   = (state_nxt != S_STROBE);
    oe_nxt   = (state_nxt == S_SETUP) || (state_nxt == S_STROBE) || (state_nxt == S_HOLD);
    data_nxt = data_245;
    if (state == S_IDLE && state_nxt == S_SETUP) data_nxt = mem[rd_ptr];
    pop      = (state == S_HOLD) && (state_nxt == S_RECOVER);
  end

endmodule
